// File: rtl/uart_ctrl_pkg.sv
// Shared constants, state encoding and frame helpers for the UART command controller.
// Pure declarations: no latency, no flow control.
package uart_ctrl_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hAB;
  localparam int         NUM_REGS = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    GET_CSUM = 3'd3,
    EXEC     = 3'd4,
    TX_LOAD  = 3'd5,
    TX_WAIT  = 3'd6
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Response is header, address, value, then address XOR value, MSB byte first.
  function automatic logic [31:0] resp_frame(input logic [7:0] addr, input logic [7:0] val);
    return {HDR_BYTE, addr, val, addr ^ val};
  endfunction

endpackage

// File: rtl/uart_resp_seq.sv
// Sends a latched 4-byte response one byte at a time; o_Tx_DV only when the transmitter is idle.
// Exactly one byte outstanding: the next byte is loaded only after tx_done for the previous one.
module uart_resp_seq import uart_ctrl_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] frame,
  input  logic        tx_active,
  input  logic        tx_done,
  output state_t      phase,
  output logic        tx_dv,
  output logic [7:0]  tx_byte
);

  logic [31:0] frame_q;
  logic [1:0]  idx;
  logic [7:0]  cur_byte;

  // Byte 0 sits in the top octet, so ~idx selects the octet counting down.
  always_comb cur_byte = frame_q[{~idx, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= IDLE;
      idx     <= 2'd0;
      frame_q <= 32'd0;
      tx_dv   <= 1'b0;
      tx_byte <= 8'h00;
    end else begin
      tx_dv <= 1'b0;
      case (phase)
        IDLE: begin
          if (start) begin
            frame_q <= frame;
            idx     <= 2'd0;
            phase   <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          if (!tx_active) begin
            tx_dv   <= 1'b1;
            tx_byte <= cur_byte;
            phase   <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (tx_done) begin
            if (idx == 2'd3) begin
              phase <= IDLE;
            end else begin
              idx   <= idx + 2'd1;
              phase <= TX_LOAD;
            end
          end
        end
        default: phase <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses AB/ADDR/DATA/CSUM frames into a 4x8 register file and answers each good frame.
// Write visible the cycle after CSUM; bytes arriving while a response is in flight are dropped.
module uart_cmd_ctrl import uart_ctrl_pkg::*; #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  input  logic        i_Tx_Active,
  input  logic        i_Tx_Done,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  output logic [31:0] o_Regs,
  output logic        o_Err,
  output logic [7:0]  o_Err_Cnt,
  output logic        o_Busy
);

  localparam int GAP_W = $clog2(TIMEOUT_CLKS + 1);

  state_t                     state;
  state_t                     seq_phase;
  logic [GAP_W-1:0]           gap;
  logic [7:0]                 addr_q;
  logic [7:0]                 data_q;
  logic [31:0]                resp_q;
  logic [NUM_REGS-1:0][7:0]   regs;

  assign o_Regs = regs;
  assign o_Busy = (state != IDLE);

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= IDLE;
      gap       <= '0;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      resp_q    <= 32'd0;
      regs      <= '0;
      o_Err     <= 1'b0;
      o_Err_Cnt <= 8'h00;
    end else begin
      o_Err <= 1'b0;
      case (state)
        IDLE: begin
          gap <= '0;
          if (i_Rx_DV && i_Rx_Byte == HDR_BYTE) state <= GET_ADDR;
        end
        GET_ADDR, GET_DATA, GET_CSUM: begin
          // A byte in the expiry cycle takes priority over the timeout.
          if (i_Rx_DV) begin
            gap <= '0;
            if (state == GET_ADDR) begin
              addr_q <= i_Rx_Byte;
              state  <= GET_DATA;
            end else if (state == GET_DATA) begin
              data_q <= i_Rx_Byte;
              state  <= GET_CSUM;
            end else if (i_Rx_Byte == (addr_q ^ data_q)) begin
              state <= EXEC;
              if (addr_q[7]) regs[addr_q[1:0]] <= data_q;
              resp_q <= resp_frame(addr_q, addr_q[7] ? data_q : regs[addr_q[1:0]]);
            end else begin
              o_Err     <= 1'b1;
              o_Err_Cnt <= sat_inc(o_Err_Cnt);
              state     <= IDLE;
            end
          end else if (gap == GAP_W'(TIMEOUT_CLKS - 1)) begin
            gap       <= '0;
            o_Err     <= 1'b1;
            o_Err_Cnt <= sat_inc(o_Err_Cnt);
            state     <= IDLE;
          end else begin
            gap <= gap + GAP_W'(1);
          end
        end
        EXEC:             state <= TX_LOAD;
        // Tracks the sequencer one cycle late; returns to IDLE once it has finished.
        TX_LOAD, TX_WAIT: state <= seq_phase;
        default:          state <= IDLE;
      endcase
    end
  end

  uart_resp_seq u_resp_seq (
    .clk       (i_Clock),
    .rst_n     (i_Rst_n),
    .start     (state == EXEC),
    .frame     (resp_q),
    .tx_active (i_Tx_Active),
    .tx_done   (i_Tx_Done),
    .phase     (seq_phase),
    .tx_dv     (o_Tx_DV),
    .tx_byte   (o_Tx_Byte)
  );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frame-level reference model checked every cycle,
// a simple transmitter responder, and literal expectations for each scenario.
module tb_uart_cmd_ctrl;

  localparam int TO = 64;

  logic        i_Clock = 1'b0;
  logic        i_Rst_n;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic        i_Tx_Active;
  logic        i_Tx_Done;
  logic        o_Tx_DV;
  logic [7:0]  o_Tx_Byte;
  logic [31:0] o_Regs;
  logic        o_Err;
  logic [7:0]  o_Err_Cnt;
  logic        o_Busy;

  always #5 i_Clock = ~i_Clock;

  uart_cmd_ctrl #(.CLKS_PER_BIT(4), .TIMEOUT_CLKS(TO)) dut (
    .i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
    .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done), .o_Tx_DV(o_Tx_DV),
    .o_Tx_Byte(o_Tx_Byte), .o_Regs(o_Regs), .o_Err(o_Err), .o_Err_Cnt(o_Err_Cnt),
    .o_Busy(o_Busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame collector, register image, error count, expected response.
  logic [7:0] m_regs [4];
  logic [7:0] m_buf  [4];
  logic [7:0] m_resp [4];
  int         m_len = 0;
  int         m_gap = 0;
  int         m_sent = 0;
  int         m_csum_cyc = 0;
  int         cyc = 0;
  logic [7:0] m_cnt = 8'h00;
  logic       m_err = 1'b0;
  logic       m_resp_on = 1'b0;
  logic       tx_out = 1'b0;
  logic       act_at_edge = 1'b0;
  logic       tx_hold = 1'b0;
  logic [7:0] ma, md, mv;
  logic [7:0] tx_log [$];

  task automatic model_clear();
    for (int k = 0; k < 4; k++) m_regs[k] = 8'h00;
    m_len = 0; m_gap = 0; m_cnt = 8'h00; m_err = 1'b0;
    m_sent = 0; m_resp_on = 1'b0; tx_out = 1'b0;
  endtask

  initial forever begin
    @(negedge i_Rst_n);
    model_clear();
  end

  initial forever begin
    @(posedge i_Clock);
    cyc++;
    act_at_edge = i_Tx_Active;
    m_err = 1'b0;
    if (!i_Rst_n) begin
      model_clear();
    end else begin
      if (i_Tx_Done) begin
        tx_out = 1'b0;
        if (m_resp_on && m_sent == 4) m_resp_on = 1'b0;
      end
      if (i_Rx_DV) begin
        if (!m_resp_on) begin
          if (m_len == 0) begin
            if (i_Rx_Byte == 8'hAB) begin m_buf[0] = 8'hAB; m_len = 1; m_gap = 0; end
          end else begin
            m_buf[m_len] = i_Rx_Byte;
            m_len++;
            m_gap = 0;
          end
          if (m_len == 4) begin
            ma = m_buf[1]; md = m_buf[2];
            if (m_buf[3] == (ma ^ md)) begin
              mv = ma[7] ? md : m_regs[ma[1:0]];
              if (ma[7]) m_regs[ma[1:0]] = md;
              m_resp[0] = 8'hAB; m_resp[1] = ma; m_resp[2] = mv; m_resp[3] = ma ^ mv;
              m_sent = 0; m_resp_on = 1'b1; m_csum_cyc = cyc;
            end else begin
              m_err = 1'b1;
              if (m_cnt != 8'hFF) m_cnt++;
            end
            m_len = 0;
          end
        end
      end else if (m_len > 0) begin
        m_gap++;
        if (m_gap == TO) begin
          m_err = 1'b1;
          if (m_cnt != 8'hFF) m_cnt++;
          m_len = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  initial forever begin
    @(negedge i_Clock);
    if (cyc > 0) begin
      chk("regs", o_Regs, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
      chk("err", 32'(o_Err), 32'(m_err));
      chk("err_cnt", 32'(o_Err_Cnt), 32'(m_cnt));
      if (o_Tx_DV) begin
        chk("tx_dv_allowed", 32'(m_resp_on && m_sent < 4 && !tx_out && !act_at_edge), 32'd1);
        if (m_resp_on && m_sent < 4) begin
          chk("tx_byte", 32'(o_Tx_Byte), 32'(m_resp[m_sent]));
          if (m_sent == 0) chk("tx_latency", 32'(cyc >= m_csum_cyc + 1), 32'd1);
          m_sent++;
        end
        tx_out = 1'b1;
        tx_log.push_back(o_Tx_Byte);
      end else if (tx_out && m_resp_on) begin
        chk("tx_byte_hold", 32'(o_Tx_Byte), 32'(m_resp[m_sent-1]));
      end
    end
  end

  // Transmitter responder: busy for 8 cycles per byte, then a one-cycle done.
  initial begin
    logic dvs;
    logic tx_busy;
    int   tx_cnt;
    tx_busy = 1'b0; tx_cnt = 0;
    i_Tx_Active = 1'b0; i_Tx_Done = 1'b0;
    forever begin
      @(negedge i_Clock);
      dvs = o_Tx_DV;
      @(posedge i_Clock);
      #1;
      i_Tx_Done = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin i_Tx_Done = 1'b1; tx_busy = 1'b0; end
      end
      if (dvs) begin tx_busy = 1'b1; tx_cnt = 8; end
      i_Tx_Active = tx_busy | tx_hold;
    end
  end

  task automatic rx(input logic [7:0] b);
    @(posedge i_Clock); #1;
    i_Rx_DV = 1'b1; i_Rx_Byte = b;
    @(posedge i_Clock); #1;
    i_Rx_DV = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_Clock);
    #1;
  endtask

  task automatic frame(input logic [31:0] f);
    rx(f[31:24]); rx(f[23:16]); rx(f[15:8]); rx(f[7:0]);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((o_Busy || m_resp_on) && n < 3000) begin
      @(posedge i_Clock);
      n++;
    end
    #1;
    chk(name, 32'(n < 3000), 32'd1);
    idle(2);
  endtask

  task automatic chk_log(input string name, input int base, input logic [31:0] exp);
    chk({name, "_count"}, tx_log.size(), base + 4);
    if (tx_log.size() >= base + 4)
      chk(name, {tx_log[base], tx_log[base+1], tx_log[base+2], tx_log[base+3]}, exp);
  endtask

  initial begin
    int n;
    i_Rst_n = 1'b0; i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00;
    idle(3);
    chk("rst_regs", o_Regs, 32'd0);
    chk("rst_tx_dv", 32'(o_Tx_DV), 32'd0);
    chk("rst_tx_byte", 32'(o_Tx_Byte), 32'd0);
    chk("rst_err", 32'(o_Err), 32'd0);
    chk("rst_err_cnt", 32'(o_Err_Cnt), 32'd0);
    chk("rst_busy", 32'(o_Busy), 32'd0);
    i_Rst_n = 1'b1;
    idle(2);

    // Write reg1, response echoes the write.
    rx(8'hAB);
    chk("A_busy_after_hdr", 32'(o_Busy), 32'd1);
    rx(8'h81); rx(8'h5A); rx(8'hDB);
    chk("A_reg1_at_n1", o_Regs, 32'h00005A00);
    wait_done("A_done");
    chk_log("A_resp", 0, 32'hAB815ADB);

    // Read reg1; bytes sent during the response are dropped.
    frame(32'hAB010001);
    chk("B_no_write", o_Regs, 32'h00005A00);
    rx(8'hAB); rx(8'h81);
    wait_done("B_done");
    chk_log("B_resp", 4, 32'hAB015A5B);

    // Bad checksum.
    frame(32'hAB821100);
    chk("C_err_pulse", 32'(o_Err), 32'd1);
    chk("C_err_cnt", 32'(o_Err_Cnt), 32'd1);
    idle(1);
    chk("C_err_single", 32'(o_Err), 32'd0);
    idle(30);
    chk("C_no_tx", tx_log.size(), 8);
    chk("C_regs", o_Regs, 32'h00005A00);
    chk("C_idle", 32'(o_Busy), 32'd0);

    // Inter-byte timeout, then a good frame.
    rx(8'hAB); rx(8'h83);
    idle(TO + 4);
    chk("D_timeout_cnt", 32'(o_Err_Cnt), 32'd2);
    chk("D_idle", 32'(o_Busy), 32'd0);
    frame(32'hAB83C340);
    chk("D_reg3", o_Regs, 32'hC3005A00);
    wait_done("D_done");
    chk_log("D_resp", 8, 32'hAB83C340);

    // Bytes landing exactly on the expiry cycle are accepted.
    rx(8'hAB); idle(TO - 2); rx(8'h80); idle(TO - 2); rx(8'h2A); idle(TO - 2); rx(8'hAA);
    chk("D_edge_reg0", o_Regs, 32'hC3005A2A);
    chk("D_edge_no_err", 32'(o_Err_Cnt), 32'd2);
    wait_done("D_edge_done");
    chk_log("D_edge_resp", 12, 32'hAB802AAA);
    // One cycle later is a timeout.
    rx(8'hAB); idle(TO - 1); rx(8'h80);
    idle(4);
    chk("D_late_cnt", 32'(o_Err_Cnt), 32'd3);
    chk("D_late_idle", 32'(o_Busy), 32'd0);

    // Leading junk, transmitter held busy at response start.
    rx(8'h12); rx(8'h34); rx(8'hAB); rx(8'h80); rx(8'hFF);
    tx_hold = 1'b1;
    rx(8'h7F);
    idle(100);
    chk("E_held_no_tx", tx_log.size(), 16);
    tx_hold = 1'b0;
    wait_done("E_done");
    chk("E_reg0", o_Regs, 32'hC3005AFF);
    chk_log("E_resp", 16, 32'hAB80FF7F);

    // Reset in the middle of response byte 2.
    frame(32'hAB8177F6);
    n = 0;
    while (m_sent != 3 && n < 500) begin
      @(posedge i_Clock);
      n++;
    end
    chk("F_reached_byte2", 32'(n < 500), 32'd1);
    #1;
    i_Rst_n = 1'b0;
    #1;
    chk("F_rst_tx_dv", 32'(o_Tx_DV), 32'd0);
    chk("F_rst_tx_byte", 32'(o_Tx_Byte), 32'd0);
    chk("F_rst_regs", o_Regs, 32'd0);
    chk("F_rst_err_cnt", 32'(o_Err_Cnt), 32'd0);
    chk("F_rst_busy", 32'(o_Busy), 32'd0);
    idle(3);
    i_Rst_n = 1'b1;
    idle(40);
    chk("F_no_more_tx", tx_log.size(), 23);
    frame(32'hAB020002);
    wait_done("F_read_done");
    chk_log("F_read_resp", 23, 32'hAB020002);
    frame(32'hAB8133B2);
    chk("F_write_reg1", o_Regs, 32'h00003300);
    wait_done("F_write_done");
    chk_log("F_write_resp", 27, 32'hAB8133B2);

    // Error counter saturates.
    for (int k = 0; k < 260; k++) frame(32'hAB821100);
    idle(2);
    chk("G_err_sat", 32'(o_Err_Cnt), 32'h000000FF);
    chk("G_regs", o_Regs, 32'h00003300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
